// File: rtl/dac_pkg.sv
// Shared definitions for the DAC write scheduler: FSM states, default
// frame geometry and the bit positions inside the {mosi, sclk, cs_n} bus.
package dac_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int CLK_DIV_DEF = 4;
    localparam int CS_GAP_DEF  = 2;

    // Bit positions inside the 3-bit dac bus.
    localparam int MOSI = 2;
    localparam int SCLK = 1;
    localparam int CS_N = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_GAP
    } state_e;

endpackage

// File: rtl/dac_serializer.sv
// Serial datapath for one DAC frame: shift register, SCLK/gap divider and
// bit counter. The scheduler FSM tells it the current and next state; every
// pin on the dac bus comes straight from a flop here.
module dac_serializer
    import dac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int CS_GAP  = CS_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  state_e            cur_st_i,
    input  state_e            nxt_st_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_data_i,
    output logic              div_done_o,
    output logic              last_bit_o,
    output logic [2:0]        dac_o
);

    localparam int BIT_W = $clog2(DATA_W) + 1;

    logic [7:0]        div_q,  div_d;
    logic [BIT_W-1:0]  bit_q,  bit_d;
    logic [DATA_W-1:0] sh_q,   sh_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              st_chg;

    assign st_chg = (nxt_st_i != cur_st_i);

    // Next-state for divider, bit counter, shift register and pin levels.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
        div_d  = div_q;
        bit_d  = bit_q;
        sh_d   = sh_q;
        cs_n_d = (nxt_st_i == ST_IDLE) || (nxt_st_i == ST_GAP);
        sclk_d = (nxt_st_i != ST_SHIFT_LO);

        // Divider reloads on every state entry and counts down to zero.
        if (st_chg) begin
            case (nxt_st_i)
                ST_GAP:  div_d = 8'(CS_GAP - 1);
                ST_IDLE: div_d = '0;
                default: div_d = 8'(CLK_DIV - 1);
            endcase
        end else if (div_q != 8'd0) begin
            div_d = div_q - 8'd1;
        end

        // mosi advances on each SHIFT_HI entry; the bit index drops when
        // a SHIFT_HI hands over to the next SHIFT_LO.
        if (load_i) begin
            sh_d  = load_data_i;
            bit_d = BIT_W'(DATA_W - 1);
        end else if (st_chg && nxt_st_i == ST_SHIFT_HI) begin
            sh_d = {sh_q[DATA_W-2:0], 1'b0};
        end else if (st_chg && nxt_st_i == ST_SHIFT_LO && cur_st_i == ST_SHIFT_HI) begin
            bit_d = bit_q - BIT_W'(1);
        end

        // Outside a frame mosi idles low.
        if (nxt_st_i == ST_IDLE || nxt_st_i == ST_GAP) begin
            sh_d = '0;
        end
    end

    // Datapath registers with synchronous reset to the idle bus levels.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            div_q  <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            sclk_q <= 1'b1;
            cs_n_q <= 1'b1;
        end else begin
            div_q  <= div_d;
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            sclk_q <= sclk_d;
            cs_n_q <= cs_n_d;
        end
    end

    assign div_done_o  = (div_q == 8'd0);
    assign last_bit_o  = (bit_q == '0);
    assign dac_o[MOSI] = sh_q[DATA_W-1];
    assign dac_o[SCLK] = sclk_q;
    assign dac_o[CS_N] = cs_n_q;

endmodule

// File: rtl/dac_sched.sv
// DAC write scheduler: arbitrates between the host and loop-filter write
// ports, handshakes the winner and drives one serial frame per grant.
module dac_sched
    import dac_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int CS_GAP  = CS_GAP_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              host_req,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_ack,
    input  logic              loop_req,
    input  logic [DATA_W-1:0] loop_data,
    output logic              loop_ack,
    output logic              busy,
    output logic              last_src,
    output logic [2:0]        dac
);

    state_e state_q, state_d;
    logic   host_ack_q, host_ack_d;
    logic   loop_ack_q, loop_ack_d;
    logic   last_src_q, last_src_d;
    logic   grant_host, grant_loop;
    logic   div_done, last_bit;

    // Arbitration, handshake and frame sequencing.
    always_comb begin
        state_d    = state_q;
        grant_host = 1'b0;
        grant_loop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // On a tie the source not served last wins.
                if (host_req && loop_req) begin
                    grant_host = last_src_q;
                    grant_loop = !last_src_q;
                end else begin
                    grant_host = host_req;
                    grant_loop = loop_req;
                end
                if (grant_host || grant_loop) state_d = ST_SETUP;
            end
            ST_SETUP:    if (div_done) state_d = ST_SHIFT_LO;
            ST_SHIFT_LO: if (div_done) state_d = ST_SHIFT_HI;
            ST_SHIFT_HI: if (div_done) state_d = last_bit ? ST_GAP : ST_SHIFT_LO;
            ST_GAP:      if (div_done) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        host_ack_d = grant_host;
        loop_ack_d = grant_loop;
        if (grant_host)      last_src_d = 1'b0;
        else if (grant_loop) last_src_d = 1'b1;
        else                 last_src_d = last_src_q;
    end

    // State and handshake registers; reset leaves the host winning the next tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            host_ack_q <= 1'b0;
            loop_ack_q <= 1'b0;
            last_src_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            host_ack_q <= host_ack_d;
            loop_ack_q <= loop_ack_d;
            last_src_q <= last_src_d;
        end
    end

    dac_serializer #(
        .DATA_W  (DATA_W),
        .CLK_DIV (CLK_DIV),
        .CS_GAP  (CS_GAP)
    ) u_ser (
        .clk         (clk),
        .rst_n       (rst_n),
        .cur_st_i    (state_q),
        .nxt_st_i    (state_d),
        .load_i      (grant_host || grant_loop),
        .load_data_i (grant_loop ? loop_data : host_data),
        .div_done_o  (div_done),
        .last_bit_o  (last_bit),
        .dac_o       (dac)
    );

    assign host_ack = host_ack_q;
    assign loop_ack = loop_ack_q;
    assign last_src = last_src_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_dac_sched.sv
// Scoreboard bench for dac_sched: a timing-level reference model predicts
// grants and frames, a monitor decodes the serial bus and compares.
module tb_dac_sched;

    localparam int DATA_W    = 16;
    localparam int CLK_DIV   = 4;
    localparam int CS_GAP    = 2;
    localparam int CS_LOW    = CLK_DIV * (1 + 2 * DATA_W);
    localparam int FRAME_LEN = CS_LOW + CS_GAP;
    localparam int CLK_DIV2  = 1;
    localparam int CS_GAP2   = 1;
    localparam int FRAME2    = CLK_DIV2 * (1 + 2 * DATA_W) + CS_GAP2;

    typedef struct {
        logic              src;
        logic [DATA_W-1:0] word;
        int                cyc;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              host_req, loop_req, host_ack, loop_ack, busy, last_src;
    logic [DATA_W-1:0] host_data, loop_data;
    logic [2:0]        dac;
    logic              h2_req, h2_ack, l2_ack, busy2, last2;
    logic [DATA_W-1:0] h2_data;
    logic [2:0]        dac2;

    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    exp_t ack_q[$];
    exp_t frame_q[$];

    always #5 clk = ~clk;

    dac_sched #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .host_req(host_req), .host_data(host_data), .host_ack(host_ack),
        .loop_req(loop_req), .loop_data(loop_data), .loop_ack(loop_ack),
        .busy(busy), .last_src(last_src), .dac(dac)
    );

    dac_sched #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV2), .CS_GAP(CS_GAP2)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .host_req(h2_req), .host_data(h2_data), .host_ack(h2_ack),
        .loop_req(1'b0), .loop_data('0), .loop_ack(l2_ack),
        .busy(busy2), .last_src(last2), .dac(dac2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: the scheduler is either free or busy for FRAME_LEN
    // cycles after a grant; ties go to whoever was not served last.
    int   m_left      = 0;
    logic m_last_loop = 1'b1;
    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            m_left      = 0;
            m_last_loop = 1'b1;
        end else if (m_left > 0) begin
            m_left--;
        end else if (host_req || loop_req) begin
            exp_t e;
            e.src  = (host_req && loop_req) ? !m_last_loop : loop_req;
            e.word = e.src ? loop_data : host_data;
            e.cyc  = cyc;
            ack_q.push_back(e);
            frame_q.push_back(e);
            m_last_loop = e.src;
            m_left      = FRAME_LEN;
        end
    end

    // Monitor: handshake, serial frame decode and busy length, sampled after the edge.
    logic              prev_cs = 1'b1, prev_sclk = 1'b1, prev_busy = 1'b0, in_frame = 1'b0;
    logic [DATA_W-1:0] rx_word;
    int                nbits, f_start, b_start, last_rise = -1;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!rst_n) begin
            check("reset_dac", dac, 3'b011);
            check("reset_busy", busy, 0);
            check("reset_acks", {host_ack, loop_ack}, 2'b00);
            check("reset_last_src", last_src, 1);
            if (in_frame && frame_q.size() != 0) void'(frame_q.pop_front());
            ack_q.delete();
            in_frame  = 1'b0;
            prev_cs   = 1'b1;
            prev_sclk = 1'b1;
            prev_busy = 1'b0;
            last_rise = -1;
        end else begin
            if (host_ack || loop_ack) begin
                check("ack_expected", ack_q.size() != 0, 1);
                if (ack_q.size() != 0) begin
                    e = ack_q.pop_front();
                    check("ack_one_hot", host_ack && loop_ack, 0);
                    check("ack_src", loop_ack, e.src);
                    check("ack_cycle", cyc, e.cyc);
                    check("last_src", last_src, e.src);
                end
            end else if (ack_q.size() != 0) begin
                check("ack_present", host_ack || loop_ack, 1);
                void'(ack_q.pop_front());
            end

            if (prev_cs && !dac[0]) begin
                in_frame = 1'b1;
                f_start  = cyc;
                nbits    = 0;
                rx_word  = '0;
                check("setup_sclk_high", dac[1], 1);
                if (frame_q.size() != 0) check("setup_mosi_msb", dac[2], frame_q[0].word[DATA_W-1]);
                if (last_rise >= 0) check("cs_gap_min", (cyc - last_rise) >= CS_GAP + 1, 1);
            end
            if (in_frame && !dac[0] && prev_sclk && !dac[1]) begin
                rx_word = {rx_word[DATA_W-2:0], dac[2]};
                nbits++;
            end
            if (in_frame && dac[0]) begin
                in_frame  = 1'b0;
                last_rise = cyc;
                check("frame_expected", frame_q.size() != 0, 1);
                if (frame_q.size() != 0) begin
                    e = frame_q.pop_front();
                    check("frame_bits", nbits, DATA_W);
                    check("frame_word", rx_word, e.word);
                    check("frame_start", f_start, e.cyc);
                    check("cs_low_len", cyc - f_start, CS_LOW);
                    check("gap_idle_levels", dac, 3'b011);
                end
            end
            if (busy && !prev_busy) b_start = cyc;
            if (!busy && prev_busy) check("busy_len", cyc - b_start, FRAME_LEN);
            prev_cs   = dac[0];
            prev_sclk = dac[1];
            prev_busy = busy;
        end
    end

    // One cycle of stimulus: move to the falling edge and release acked requests.
    task automatic step();
        @(negedge clk);
        if (host_ack) host_req = 1'b0;
        if (loop_ack) loop_req = 1'b0;
        if (h2_ack)   h2_req   = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        step();
        while ((host_req || loop_req || busy) && n < 3000) begin
            step();
            n++;
        end
        check("idle_within_budget", n < 3000, 1);
        step();
    endtask

    // Directed frame on the fast instance; the word is all-ones or all-zeros.
    task automatic sweep(input logic [DATA_W-1:0] w);
        int   n = 0, blen = 0, sbits = 0, nack = 0;
        logic ps = 1'b1;
        h2_data = w;
        h2_req  = 1'b1;
        while (n < 200) begin
            step();
            n++;
            if (h2_ack) nack++;
            if (busy2) blen++;
            if (!dac2[0] && ps && !dac2[1]) begin
                sbits++;
                check("sweep_mosi", dac2[2], w[0]);
            end
            ps = dac2[1];
            if (blen > 0 && !busy2 && !h2_req) break;
        end
        check("sweep_ack_count", nack, 1);
        check("sweep_frame_len", blen, FRAME2);
        check("sweep_bits", sbits, DATA_W);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        host_req  = 1'b0;
        loop_req  = 1'b0;
        host_data = '0;
        loop_data = '0;
        h2_req    = 1'b0;
        h2_data   = '0;
        rst_n     = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // Two ties after reset: host, loop, then host again.
        for (int t = 0; t < 2; t++) begin
            host_data = DATA_W'($urandom);
            loop_data = DATA_W'($urandom);
            host_req  = 1'b1;
            loop_req  = 1'b1;
            wait_idle();
        end

        // Host-only write of a known pattern.
        host_data = 16'hA5C3;
        host_req  = 1'b1;
        wait_idle();

        // Loop request arriving 10 cycles into a host frame.
        host_data = DATA_W'($urandom);
        host_req  = 1'b1;
        repeat (10) step();
        loop_data = DATA_W'($urandom);
        loop_req  = 1'b1;
        wait_idle();

        // Reset around bit 7, then a tie that must restart a full frame with host first.
        host_data = DATA_W'($urandom);
        host_req  = 1'b1;
        repeat (1 + CLK_DIV + 2 * CLK_DIV * 8) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (3) step();
        host_data = DATA_W'($urandom);
        loop_data = DATA_W'($urandom);
        host_req  = 1'b1;
        loop_req  = 1'b1;
        wait_idle();

        // Random request patterns, idle or mid-frame.
        for (int i = 0; i < 12; i++) begin
            int p;
            repeat ($urandom_range(0, 150)) step();
            p = $urandom_range(0, 2);
            if (p != 1 && !host_req) begin
                host_data = DATA_W'($urandom);
                host_req  = 1'b1;
            end
            if (p != 0 && !loop_req) begin
                loop_data = DATA_W'($urandom);
                loop_req  = 1'b1;
            end
        end
        wait_idle();

        sweep(16'hFFFF);
        sweep(16'h0000);

        check("scoreboard_drained", ack_q.size() + frame_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dac_sched.md
DAC_SCHED -- requirements
Module: dac_sched

Interface
REQ-001: Parameter DATA_W, default 16: DAC frame width in bits, MSB first.
REQ-002: Parameter CLK_DIV, default 4: SCLK half-period in clk cycles, legal range 1..255.
REQ-003: Parameter CS_GAP, default 2: minimum clk cycles with CS_N high between frames, legal range 1..255.
REQ-004: clk  input  1  sole clock, the 10 MHz oscillator domain; one clock; reset is synchronous and active-low.
REQ-005: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-006: host_req  input  1  host (SPI-loaded) write request; held high until host_ack.
REQ-007: host_data  input  DATA_W  host DAC word; must be stable while host_req is high.
REQ-008: host_ack  output  1  one-cycle pulse: host word accepted.
REQ-009: loop_req  input  1  loop-filter write request; held high until loop_ack.
REQ-010: loop_data  input  DATA_W  loop-filter DAC word; must be stable while loop_req is high.
REQ-011: loop_ack  output  1  one-cycle pulse: loop word accepted.
REQ-012: busy  output  1  high in every state except IDLE.
REQ-013: last_src  output  1  source of the most recent accepted word: 0 = host, 1 = loop.
REQ-014: dac  output  3  {mosi, sclk, cs_n}, all driven directly from flops.

Function
REQ-015: FSM states: IDLE, SETUP, SHIFT_LO, SHIFT_HI, GAP.
REQ-016: IDLE outputs: cs_n=1, sclk=1, mosi=0.
REQ-017: Accept rules in IDLE: exactly one req high -> grant it; both high -> grant the source not granted last; after reset the host wins the first tie.
REQ-018: Accept timing: a req sampled high in IDLE at edge N gives, at edge N+1, the ack pulse, word latched into shift register, state=SETUP, cs_n=0, mosi=word[DATA_W-1], sclk=1, last_src updated.
REQ-019: SETUP lasts CLK_DIV cycles, then SHIFT_LO.
REQ-020: SHIFT_LO: sclk=0 for CLK_DIV cycles, mosi held; the DAC samples mosi on the falling sclk edge.
REQ-021: SHIFT_HI: sclk=1 for CLK_DIV cycles; on entry mosi advances to the next lower bit; after CLK_DIV cycles -> SHIFT_LO.
REQ-022: After the SHIFT_HI that follows the final (bit 0) SHIFT_LO, cs_n rises and the FSM enters GAP.
REQ-023: GAP: cs_n=1, sclk=1, mosi=0 for CS_GAP cycles, then IDLE.
REQ-024: Frame length: accept to return-to-IDLE = CLK_DIV*(1+2*DATA_W) + CS_GAP cycles (134 at defaults).
REQ-025: No back-to-back acceptance: a new req is sampled only in IDLE, so cs_n is high for at least CS_GAP+1 cycles between frames.
REQ-026: A req asserted while busy stays pending and is served by REQ-017 on return to IDLE.
REQ-027: The bit counter is log2(DATA_W)+1 bits wide; the divider counter is 8 bits and counts down from CLK_DIV-1 to 0.

Reset
REQ-028: rst_n=0 at any edge forces the next state: IDLE, dac={0,1,1}, host_ack=0, loop_ack=0, busy=0, last_src=1 (host wins the next tie), counters=0.
REQ-029: Reset mid-frame aborts the frame; cs_n goes high on the next edge; the partial word is discarded; no ack is reissued.

Structure
REQ-030: A shared package dac_pkg holds the state enumeration, DATA_W/CLK_DIV/CS_GAP defaults and the dac bit-position constants MOSI=2, SCLK=1, CS_N=0.
REQ-031: One sub-module, dac_serializer, contains the shift register, divider and bit counter; dac_sched contains the arbitration and the handshake.

Verification
REQ-032: Host-only write: host_req=1, host_data=16'hA5C3 -> host_ack at N+1; 16 falling sclk edges sample 1010_0101_1100_0011; cs_n low for 132 cycles; busy for 134 cycles.
REQ-033: Tie after reset: host_req and loop_req rise on the same edge -> host served first and loop second; then another tie -> host served first again.
REQ-034: Request during a frame: loop_req rises 10 cycles into a host frame -> loop_ack exactly 1 cycle after the host frame returns to IDLE; cs_n gap = CS_GAP+1 = 3 cycles.
REQ-035: Reset mid-frame: rst_n=0 at bit 7 -> next edge dac={0,1,1} and busy=0; no ack; the following request restarts with a full 16-bit frame.
REQ-036: Parameter sweep: CLK_DIV=1, CS_GAP=1, data 16'hFFFF and 16'h0000 -> frame length 34 cycles; mosi constant across all sampled bits.
